control_sequencer: RTL and testbench
====================================

# control_sequencer

Control sequencer for the 16-bit SAP computer: the consumer of the instruction register contents. It runs the fetch/execute T-state machine, decodes the opcode field (ir[15:12]) of the instruction word, and drives every datapath load/enable strobe, including the ir_write strobe that loads the instruction register. One instance sits in the top level between the instruction register, flags register and the shared 16-bit bus.

## Interface
- No parameters; opcode width 4, instruction width 16 fixed.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low freezes the sequencer
- ir  in  16  instruction register output; opcode = ir[15:12]
- carry_flag, zero_flag  in  1 each  registered ALU flags
- pc_oe, pc_inc, pc_write  out  1 each  program counter drive/increment/load
- mar_write  out  1  memory address register load
- mem_oe, mem_write  out  1 each  RAM read onto bus / RAM write from bus
- ir_write, ir_oe  out  1 each  IR load / IR operand (ir[11:0], zero-extended) onto bus
- a_write, a_oe, b_write  out  1 each  A/B register strobes
- alu_oe, alu_sub, flags_write  out  1 each  ALU result onto bus, subtract select, flag capture
- out_write  out  1  output register load
- halted  out  1  high in HALT state
- state  out  3  current state encoding, debug

## Operation
- States: FETCH0, FETCH1, EXEC0, EXEC1, EXEC2, HALT.
- FETCH0: pc_oe, mar_write. FETCH1: mem_oe, ir_write, pc_inc. Always FETCH0→FETCH1→EXEC0.
- EXEC steps by opcode; final step returns to FETCH0:
  - 0x0 NOP: EXEC0 nothing.
  - 0x1 LDA: EXEC0 ir_oe+mar_write; EXEC1 mem_oe+a_write.
  - 0x2 ADD / 0x3 SUB: EXEC0 ir_oe+mar_write; EXEC1 mem_oe+b_write; EXEC2 alu_oe+a_write+flags_write, alu_sub=1 for SUB only.
  - 0x4 STA: EXEC0 ir_oe+mar_write; EXEC1 a_oe+mem_write.
  - 0x5 LDI: EXEC0 ir_oe+a_write.
  - 0x6 JMP: EXEC0 ir_oe+pc_write.
  - 0x7 JC / 0x8 JZ: EXEC0 ir_oe+pc_write only if carry_flag / zero_flag is 1; otherwise no strobes. Flag sampled in EXEC0.
  - 0xE OUT: EXEC0 a_oe+out_write.
  - 0xF HLT: EXEC0 no strobes, next state HALT.
  - 0x9–0xD: treated as NOP.
- HALT: all strobes 0, halted=1, held until rst.
- en low: state register holds, all strobes forced 0; resumes in the same state when en returns high. Takes effect in any state including HALT.
- At most one of pc_oe, mem_oe, ir_oe, a_oe, alu_oe is high in any cycle.

## Timing
- State registered; strobes combinational from state, ir, flags, en.
- rst high: next state FETCH0. Every strobe forced 0 in the rst cycle. halted=0, state=FETCH0 from the first cycle after reset. Reset mid-instruction aborts it with no partial strobes.
- ir is loaded at the FETCH1 clock edge, so EXEC0 decodes the new instruction. Decode never uses ir during FETCH0/FETCH1.
- Instruction length in cycles: NOP/LDI/JMP/JC/JZ/OUT/undefined 3, LDA/STA 4, ADD/SUB 5, HLT 3 then HALT.
- A jump takes effect on the next FETCH0: pc_oe drives the new target.

## Structure
- sap_pkg holds:
  - opcode constants: OP_NOP … OP_HLT
  - state enum and its 3-bit encoding
  - IR field positions: opcode [15:12], operand [11:0]
- Optional combinational sub-module ctrl_decode(state, opcode, flags) → strobe vector. The state register and next-state logic stay in control_sequencer.

## Test plan
- Reset, ir=0x100A (LDA):
  - strobes 0 during rst.
  - FETCH0 pc_oe+mar_write; FETCH1 mem_oe+ir_write+pc_inc; EXEC0 ir_oe+mar_write; EXEC1 mem_oe+a_write.
  - FETCH0 again on cycle 5.
- ir=0x200B (ADD) then 0x300B (SUB): EXEC2 alu_oe+a_write+flags_write with alu_sub 0 then 1. Each takes 5 cycles.
- ir=0x7020 (JC):
  - carry_flag=0: EXEC0 no strobes, 3-cycle instruction.
  - carry_flag=1: EXEC0 ir_oe+pc_write.
  - Repeat with 0x8020 and zero_flag.
- ir=0xF000 (HLT): halted=1 and all strobes 0 for 20 cycles; rst pulse returns state to FETCH0 with halted=0.
- ADD with en low for 3 cycles entering EXEC1: state stays EXEC1 and strobes stay 0. On re-enable, mem_oe+b_write fire exactly once, then EXEC2.
- Random opcode stream with random en/rst: assert one-hot bus drivers and correct per-opcode length. Opcodes 0x9–0xD behave as NOP (3 cycles, no EXEC strobes).

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the SAP-16 control sequencer: opcodes, states, strobe bundle.
package control_sequencer_pkg;

  localparam int unsigned InstrWidth  = 16;
  localparam int unsigned OpcodeWidth = 4;
  localparam int unsigned OpcodeMsb   = 15;
  localparam int unsigned OpcodeLsb   = 12;
  localparam int unsigned OperandMsb  = 11;
  localparam int unsigned OperandLsb  = 0;

  typedef logic [OpcodeWidth-1:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_JZ  = 4'h8;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    StFetch0 = 3'd0,
    StFetch1 = 3'd1,
    StExec0  = 3'd2,
    StExec1  = 3'd3,
    StExec2  = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic pc_write;
    logic mar_write;
    logic mem_oe;
    logic mem_write;
    logic ir_write;
    logic ir_oe;
    logic a_write;
    logic a_oe;
    logic b_write;
    logic alu_oe;
    logic alu_sub;
    logic flags_write;
    logic out_write;
  } ctrl_t;

  function automatic opcode_t get_opcode(logic [InstrWidth-1:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

  // Number of EXEC steps an opcode occupies; undefined opcodes behave as NOP.
  function automatic logic [1:0] exec_steps(opcode_t op);
    case (op)
      OP_LDA, OP_STA: return 2'd2;
      OP_ADD, OP_SUB: return 2'd3;
      default:        return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: decode inputs in, load/enable strobes out.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic                  en;
  logic [InstrWidth-1:0] ir;
  logic                  carry_flag;
  logic                  zero_flag;

  logic pc_oe, pc_inc, pc_write;
  logic mar_write;
  logic mem_oe, mem_write;
  logic ir_write, ir_oe;
  logic a_write, a_oe, b_write;
  logic alu_oe, alu_sub, flags_write;
  logic out_write;
  logic halted;
  logic [2:0] state;

  modport master (
    input  en, ir, carry_flag, zero_flag,
    output pc_oe, pc_inc, pc_write, mar_write, mem_oe, mem_write, ir_write, ir_oe,
           a_write, a_oe, b_write, alu_oe, alu_sub, flags_write, out_write, halted, state
  );

  modport slave (
    output en, ir, carry_flag, zero_flag,
    input  pc_oe, pc_inc, pc_write, mar_write, mem_oe, mem_write, ir_write, ir_oe,
           a_write, a_oe, b_write, alu_oe, alu_sub, flags_write, out_write, halted, state
  );

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational strobe decode from current T-state, opcode and flags.
module control_sequencer_decode
  import control_sequencer_pkg::*;
(
  input  state_e  state_i,
  input  opcode_t opcode_i,
  input  logic    carry_i,
  input  logic    zero_i,
  output ctrl_t   ctrl_o
);

  // One bus driver per step by construction; all strobes default low.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch0: begin
        ctrl_o.pc_oe     = 1'b1;
        ctrl_o.mar_write = 1'b1;
      end
      StFetch1: begin
        ctrl_o.mem_oe   = 1'b1;
        ctrl_o.ir_write = 1'b1;
        ctrl_o.pc_inc   = 1'b1;
      end
      StExec0: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.ir_oe     = 1'b1;
            ctrl_o.mar_write = 1'b1;
          end
          OP_LDI: begin
            ctrl_o.ir_oe   = 1'b1;
            ctrl_o.a_write = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.ir_oe    = 1'b1;
            ctrl_o.pc_write = 1'b1;
          end
          OP_JC: begin
            ctrl_o.ir_oe    = carry_i;
            ctrl_o.pc_write = carry_i;
          end
          OP_JZ: begin
            ctrl_o.ir_oe    = zero_i;
            ctrl_o.pc_write = zero_i;
          end
          OP_OUT: begin
            ctrl_o.a_oe      = 1'b1;
            ctrl_o.out_write = 1'b1;
          end
          default: ;
        endcase
      end
      StExec1: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.mem_oe  = 1'b1;
            ctrl_o.a_write = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.mem_oe  = 1'b1;
            ctrl_o.b_write = 1'b1;
          end
          OP_STA: begin
            ctrl_o.a_oe      = 1'b1;
            ctrl_o.mem_write = 1'b1;
          end
          default: ;
        endcase
      end
      StExec2: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o.alu_oe      = 1'b1;
          ctrl_o.a_write     = 1'b1;
          ctrl_o.flags_write = 1'b1;
          ctrl_o.alu_sub     = (opcode_i == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-16 fetch/execute sequencer: T-state register, next-state logic, gated strobes.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master ctrl
);

  state_e  state_q, state_d;
  opcode_t opcode;
  ctrl_t   dec_ctrl, strobes;
  logic    unused_operand;

  assign opcode         = get_opcode(ctrl.ir);
  assign unused_operand = ^ctrl.ir[OperandMsb:OperandLsb];

  // State register; synchronous reset restarts at FETCH0.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch0;
    else     state_q <= state_d;
  end

  // Next state: fixed fetch pair, then opcode-dependent EXEC length; en low holds.
  always_comb begin
    state_d = state_q;
    if (ctrl.en) begin
      case (state_q)
        StFetch0: state_d = StFetch1;
        StFetch1: state_d = StExec0;
        StExec0: begin
          if (opcode == OP_HLT)                state_d = StHalt;
          else if (exec_steps(opcode) == 2'd1) state_d = StFetch0;
          else                                 state_d = StExec1;
        end
        StExec1:  state_d = (exec_steps(opcode) == 2'd2) ? StFetch0 : StExec2;
        StExec2:  state_d = StFetch0;
        StHalt:   state_d = StHalt;
        default:  state_d = StFetch0;
      endcase
    end
  end

  control_sequencer_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .carry_i  (ctrl.carry_flag),
    .zero_i   (ctrl.zero_flag),
    .ctrl_o   (dec_ctrl)
  );

  // Strobes are suppressed while frozen or in the reset cycle so aborts leave no partial writes.
  always_comb begin
    strobes = '0;
    if (ctrl.en && !rst) strobes = dec_ctrl;
  end

  assign ctrl.pc_oe       = strobes.pc_oe;
  assign ctrl.pc_inc      = strobes.pc_inc;
  assign ctrl.pc_write    = strobes.pc_write;
  assign ctrl.mar_write   = strobes.mar_write;
  assign ctrl.mem_oe      = strobes.mem_oe;
  assign ctrl.mem_write   = strobes.mem_write;
  assign ctrl.ir_write    = strobes.ir_write;
  assign ctrl.ir_oe       = strobes.ir_oe;
  assign ctrl.a_write     = strobes.a_write;
  assign ctrl.a_oe        = strobes.a_oe;
  assign ctrl.b_write     = strobes.b_write;
  assign ctrl.alu_oe      = strobes.alu_oe;
  assign ctrl.alu_sub     = strobes.alu_sub;
  assign ctrl.flags_write = strobes.flags_write;
  assign ctrl.out_write   = strobes.out_write;
  assign ctrl.halted      = (state_q == StHalt);
  assign ctrl.state       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector table plus hand sequences and a modelled random stream.
module tb_control_sequencer;

  localparam logic [14:0] PC_OE = 15'h4000, PC_INC = 15'h2000, PC_WR = 15'h1000;
  localparam logic [14:0] MAR_WR = 15'h0800, MEM_OE = 15'h0400, MEM_WR = 15'h0200;
  localparam logic [14:0] IR_WR = 15'h0100, IR_OE = 15'h0080, A_WR = 15'h0040;
  localparam logic [14:0] A_OE = 15'h0020, B_WR = 15'h0010, ALU_OE = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004, FLG_WR = 15'h0002, OUT_WR = 15'h0001;
  localparam logic [14:0] F0S = PC_OE | MAR_WR;
  localparam logic [14:0] F1S = MEM_OE | IR_WR | PC_INC;

  localparam logic [2:0] SF0 = 3'd0, SF1 = 3'd1, SE0 = 3'd2, SE1 = 3'd3, SE2 = 3'd4;
  localparam logic [2:0] SH = 3'd5;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] ir;
    logic        c;
    logic        z;
    logic        chk;
    logic [2:0]  st;
    logic [14:0] strb;
    logic        hlt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] act_strb();
    return {bus.pc_oe, bus.pc_inc, bus.pc_write, bus.mar_write, bus.mem_oe, bus.mem_write,
            bus.ir_write, bus.ir_oe, bus.a_write, bus.a_oe, bus.b_write, bus.alu_oe,
            bus.alu_sub, bus.flags_write, bus.out_write};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic e, input logic [15:0] ir, input logic c,
                     input logic z, input logic chk, input logic [2:0] st,
                     input logic [14:0] strb, input logic hlt);
    vec_t v;
    v.rst = r; v.en = e; v.ir = ir; v.c = c; v.z = z;
    v.chk = chk; v.st = st; v.strb = strb; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 2 time units later, well before the next rising edge.
  task automatic drive(input logic r, input logic e, input logic [15:0] ir, input logic c,
                       input logic z);
    @(negedge clk);
    rst = r; bus.en = e; bus.ir = ir; bus.carry_flag = c; bus.zero_flag = z;
    #2;
  endtask

  // Instruction in normal run: fetch pair then the listed EXEC strobes.
  task automatic add_instr(input logic [15:0] ir, input logic c, input logic z,
                           input logic [14:0] e0, input logic [14:0] e1, input logic [14:0] e2,
                           input int nexec);
    add(0, 1, ir, c, z, 1, SF0, F0S, 0);
    add(0, 1, ir, c, z, 1, SF1, F1S, 0);
    add(0, 1, ir, c, z, 1, SE0, e0, 0);
    if (nexec > 1) add(0, 1, ir, c, z, 1, SE1, e1, 0);
    if (nexec > 2) add(0, 1, ir, c, z, 1, SE2, e2, 0);
  endtask

  function automatic int steps(input int op);
    case (op)
      1, 4:    return 2;
      2, 3:    return 3;
      default: return 1;
    endcase
  endfunction

  initial begin
    logic [2:0] m_st;
    int         op;
    logic       r, e;
    logic [15:0] ir;

    rst = 1'b1; bus.en = 1'b1; bus.ir = 16'h0; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;

    // Reset then LDA (F0 following each instruction confirms its length)
    add(1, 1, 16'h100A, 0, 0, 0, SF0, 15'h0, 0);
    add(1, 1, 16'h100A, 0, 0, 1, SF0, 15'h0, 0);
    add_instr(16'h100A, 0, 0, IR_OE | MAR_WR, MEM_OE | A_WR, 0, 2);
    add_instr(16'h200B, 0, 0, IR_OE | MAR_WR, MEM_OE | B_WR, ALU_OE | A_WR | FLG_WR, 3);
    add_instr(16'h300B, 0, 0, IR_OE | MAR_WR, MEM_OE | B_WR,
              ALU_OE | A_WR | FLG_WR | ALU_SUB, 3);
    add_instr(16'h7020, 0, 1, 15'h0, 0, 0, 1);
    add_instr(16'h7020, 1, 0, IR_OE | PC_WR, 0, 0, 1);
    add_instr(16'h8020, 1, 0, 15'h0, 0, 0, 1);
    add_instr(16'h8020, 0, 1, IR_OE | PC_WR, 0, 0, 1);
    add_instr(16'h4011, 0, 0, IR_OE | MAR_WR, A_OE | MEM_WR, 0, 2);
    add_instr(16'h5007, 0, 0, IR_OE | A_WR, 0, 0, 1);
    add_instr(16'h6030, 0, 0, IR_OE | PC_WR, 0, 0, 1);
    add_instr(16'hE000, 0, 0, A_OE | OUT_WR, 0, 0, 1);
    add_instr(16'hB000, 0, 0, 15'h0, 0, 0, 1);
    add_instr(16'h0000, 0, 0, 15'h0, 0, 0, 1);
    // Reset mid-LDA: no EXEC1 strobes, restart at FETCH0
    add_instr(16'h100A, 0, 0, IR_OE | MAR_WR, 0, 0, 1);
    add(1, 1, 16'h100A, 0, 0, 1, SE1, 15'h0, 0);
    // ADD frozen for 3 cycles in EXEC1, plus a freeze in FETCH0
    add(0, 0, 16'h200B, 0, 0, 1, SF0, 15'h0, 0);
    add_instr(16'h200B, 0, 0, IR_OE | MAR_WR, 0, 0, 1);
    add(0, 0, 16'h200B, 0, 0, 1, SE1, 15'h0, 0);
    add(0, 0, 16'h200B, 0, 0, 1, SE1, 15'h0, 0);
    add(0, 0, 16'h200B, 0, 0, 1, SE1, 15'h0, 0);
    add(0, 1, 16'h200B, 0, 0, 1, SE1, MEM_OE | B_WR, 0);
    add(0, 1, 16'h200B, 0, 0, 1, SE2, ALU_OE | A_WR | FLG_WR, 0);
    add_instr(16'hF000, 1, 1, 15'h0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ir, vecs[i].c, vecs[i].z);
      check($sformatf("vec%0d strobes", i), {17'h0, act_strb()}, {17'h0, vecs[i].strb});
      if (vecs[i].chk) begin
        check($sformatf("vec%0d state", i), {29'h0, bus.state}, {29'h0, vecs[i].st});
        check($sformatf("vec%0d halted", i), {31'h0, bus.halted}, {31'h0, vecs[i].hlt});
      end
    end

    // HALT holds for 20 cycles, then stays through en low
    for (int i = 0; i < 22; i++) begin
      drive(0, (i < 20), 16'hF000, 1, 1);
      check($sformatf("halt%0d state", i), {29'h0, bus.state}, {29'h0, SH});
      check($sformatf("halt%0d halted", i), {31'h0, bus.halted}, 32'h1);
      check($sformatf("halt%0d strobes", i), {17'h0, act_strb()}, 32'h0);
    end
    drive(1, 1, 16'hF000, 1, 1);
    check("halt rst strobes", {17'h0, act_strb()}, 32'h0);
    drive(0, 1, 16'h0000, 0, 0);
    check("post-halt state", {29'h0, bus.state}, {29'h0, SF0});
    check("post-halt halted", {31'h0, bus.halted}, 32'h0);
    check("post-halt strobes", {17'h0, act_strb()}, {17'h0, F0S});

    // Random stream against a length model; now in FETCH1 after the cycle above
    m_st = SF1;
    op   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (m_st == SF0) op = int'($urandom_range(0, 15));
      ir = {op[3:0], 12'($urandom())};
      drive(r, e, ir, 1'($urandom()), 1'($urandom()));
      check($sformatf("rnd%0d state", cyc), {29'h0, bus.state}, {29'h0, m_st});
      check($sformatf("rnd%0d onehot", cyc),
            {31'h0, ($countones({bus.pc_oe, bus.mem_oe, bus.ir_oe, bus.a_oe, bus.alu_oe}) <= 1)},
            32'h1);
      if (r || !e)
        check($sformatf("rnd%0d gated", cyc), {17'h0, act_strb()}, 32'h0);
      else if (m_st == SE0 && op >= 9 && op <= 13)
        check($sformatf("rnd%0d undef", cyc), {17'h0, act_strb()}, 32'h0);
      if (r) m_st = SF0;
      else if (e) begin
        case (m_st)
          SF0: m_st = SF1;
          SF1: m_st = SE0;
          SE0: m_st = (op == 15) ? SH : ((steps(op) == 1) ? SF0 : SE1);
          SE1: m_st = (steps(op) == 2) ? SF0 : SE2;
          SE2: m_st = SF0;
          default: m_st = SH;
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
